adam_rst_seq: RTL and testbench

FPGA-top reset sequencer that sits directly upstream of the source sequence (src_seq.rst) and of the per-domain resets.
- Combines an asynchronous power-on reset, a raw active-low board button and a synchronous software/debug reset request.
- Synchronizes and debounces the button, stretches reset, then releases NO_STAGES reset outputs one after another in fixed order (stage 0 first).
- Reports the cause of the most recent reset.

---
 rtl/adam_rst_seq.sv | 164 ++++++++++++++++
 tb/tb_adam_rst_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/adam_rst_seq.sv
// Board-level reset sequencer. It merges power-on, the debounced button and the request
// reset, stretches the merged reset, then releases the staged reset outputs one after another.
module adam_rst_seq #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int STRETCH_CYCLES  = 16,
   parameter int STAGE_GAP       = 4,
   parameter int NO_STAGES       = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 btn_n,
   input  logic                 req_rst,
   output logic [NO_STAGES-1:0] stage_rst,
   output logic                 all_released,
   output logic [1:0]           cause
);

   localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int STR_W = $clog2(STRETCH_CYCLES + 1);
   localparam int GAP_W = $clog2(STAGE_GAP + 1);

   localparam logic [DEB_W-1:0]     DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [STR_W-1:0]     STR_LAST   = STR_W'(STRETCH_CYCLES - 1);
   localparam logic [GAP_W-1:0]     GAP_LAST   = GAP_W'(STAGE_GAP - 1);
   localparam logic [NO_STAGES-1:0] STAGES_ALL = '1;

   localparam logic [1:0] CAUSE_POR = 2'd0;
   localparam logic [1:0] CAUSE_BTN = 2'd1;
   localparam logic [1:0] CAUSE_REQ = 2'd2;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   db_level_q, db_level_d;
   logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
   logic [STR_W-1:0]       str_cnt_q, str_cnt_d;
   logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
   logic [NO_STAGES-1:0]   stage_rst_q, stage_rst_d;
   logic                   all_released_q, all_released_d;
   logic [1:0]             cause_q, cause_d;

   logic btn_sync;
   logic pressed;
   logic assert_evt;
   logic restart;

   assign btn_sync   = sync_q[SYNC_STAGES-1];
   assign pressed    = ~db_level_q;
   assign assert_evt = pressed | req_rst;
   assign restart    = assert_evt && (state_q != ST_HOLD);

   // The debounce counter only advances while the synchronized button disagrees with the
   // accepted level, so any return to agreement throws away the partial count.
   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], btn_n};
      db_level_d = db_level_q;
      deb_cnt_d  = '0;
      if (btn_sync != db_level_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            db_level_d = btn_sync;
         end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      str_cnt_d      = str_cnt_q;
      gap_cnt_d      = gap_cnt_q;
      stage_rst_d    = stage_rst_q;
      all_released_d = all_released_q;
      cause_d        = cause_q;

      if (restart) begin
         state_d        = ST_HOLD;
         str_cnt_d      = '0;
         gap_cnt_d      = '0;
         stage_rst_d    = STAGES_ALL;
         all_released_d = 1'b0;
         cause_d        = pressed ? CAUSE_BTN : CAUSE_REQ;
      end else begin
         case (state_q)
            ST_HOLD: begin
               stage_rst_d    = STAGES_ALL;
               all_released_d = 1'b0;
               gap_cnt_d      = '0;
               if (assert_evt) begin
                  str_cnt_d = '0;
               end else if (str_cnt_q == STR_LAST) begin
                  // Stage 0 drops on the same edge that leaves HOLD.
                  str_cnt_d   = '0;
                  stage_rst_d = STAGES_ALL << 1;
                  if (stage_rst_d == '0) begin
                     all_released_d = 1'b1;
                     state_d        = ST_RUN;
                  end else begin
                     state_d = ST_RELEASE;
                  end
               end else begin
                  str_cnt_d = str_cnt_q + STR_W'(1);
               end
            end
            ST_RELEASE: begin
               if (gap_cnt_q == GAP_LAST) begin
                  gap_cnt_d   = '0;
                  stage_rst_d = stage_rst_q << 1;
                  if (stage_rst_d == '0) begin
                     all_released_d = 1'b1;
                     state_d        = ST_RUN;
                  end
               end else begin
                  gap_cnt_d = gap_cnt_q + GAP_W'(1);
               end
            end
            ST_RUN: begin
               state_d = ST_RUN;
            end
            default: begin
               state_d        = ST_HOLD;
               str_cnt_d      = '0;
               gap_cnt_d      = '0;
               stage_rst_d    = STAGES_ALL;
               all_released_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_HOLD;
         sync_q         <= '1;
         db_level_q     <= 1'b1;
         deb_cnt_q      <= '0;
         str_cnt_q      <= '0;
         gap_cnt_q      <= '0;
         stage_rst_q    <= STAGES_ALL;
         all_released_q <= 1'b0;
         cause_q        <= CAUSE_POR;
      end else begin
         state_q        <= state_d;
         sync_q         <= sync_d;
         db_level_q     <= db_level_d;
         deb_cnt_q      <= deb_cnt_d;
         str_cnt_q      <= str_cnt_d;
         gap_cnt_q      <= gap_cnt_d;
         stage_rst_q    <= stage_rst_d;
         all_released_q <= all_released_d;
         cause_q        <= cause_d;
      end
   end

   assign stage_rst    = stage_rst_q;
   assign all_released = all_released_q;
   assign cause        = cause_q;

endmodule

// File: tb/tb_adam_rst_seq.sv
// Scoreboard bench for adam_rst_seq: stimulus queues the expected output transitions with the
// cycle on which each must appear, and a monitor pops one whenever the outputs change.
module tb_adam_rst_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_n;
   logic       req_rst;
   logic [2:0] stage_rst;
   logic       all_released;
   logic [1:0] cause;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         cyc;
      logic [2:0] stage;
      logic       rel;
      logic [1:0] cause;
      string      name;
   } exp_t;

   exp_t sb[$];

   adam_rst_seq #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(8),
      .STRETCH_CYCLES (16),
      .STAGE_GAP      (4),
      .NO_STAGES      (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_n       (btn_n),
      .req_rst     (req_rst),
      .stage_rst   (stage_rst),
      .all_released(all_released),
      .cause       (cause)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Any change of the outputs must match the oldest queued transition, both in value and cycle.
   logic [5:0] prev = 6'b111_0_00;
   always @(negedge clk) begin
      logic [5:0] cur;
      logic [5:0] req;
      exp_t       e;
      cur = {stage_rst, all_released, cause};
      if (cur !== prev) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_change: cycle %0d value %b, required no change from %b",
                     cyc, cur, prev);
         end else begin
            e   = sb.pop_front();
            req = {e.stage, e.rel, e.cause};
            if (cur !== req || cyc != e.cyc) begin
               errors++;
               $display("[TB] FAIL %s: cycle %0d value %b, required cycle %0d value %b",
                        e.name, cyc, cur, e.cyc, req);
            end
         end
         prev = cur;
      end
   end

   task automatic push_exp(input int c, input logic [2:0] s, input logic r,
                           input logic [1:0] ca, input string name);
      exp_t e;
      e.cyc   = c;
      e.stage = s;
      e.rel   = r;
      e.cause = ca;
      e.name  = name;
      sb.push_back(e);
   endtask

   task automatic push_release(input int base, input logic [1:0] ca, input string name);
      push_exp(base + 16, 3'b110, 1'b0, ca, {name, "_stage0"});
      push_exp(base + 20, 3'b100, 1'b0, ca, {name, "_stage1"});
      push_exp(base + 24, 3'b000, 1'b1, ca, {name, "_stage2"});
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic apply_stimulus(input int at, input logic b, input logic r);
      wait_to(at);
      btn_n   = b;
      req_rst = r;
   endtask

   task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   initial begin
      int c3;
      rst     = 1'b1;
      btn_n   = 1'b1;
      req_rst = 1'b0;

      wait_to(3);
      check_output("reset_stage", 8'(stage_rst), 8'b111);
      check_output("reset_all_released", 8'(all_released), 8'd0);
      check_output("reset_cause", 8'(cause), 8'd0);

      $display("[TB] power-on sequence");
      push_release(5, 2'd0, "por");
      wait_to(5);
      rst = 1'b0;

      $display("[TB] 7-cycle button glitch");
      apply_stimulus(35, 1'b0, 1'b0);
      apply_stimulus(42, 1'b1, 1'b0);
      wait_to(59);
      check_output("glitch_stage", 8'(stage_rst), 8'b000);
      check_output("glitch_all_released", 8'(all_released), 8'd1);

      $display("[TB] 8-cycle button press");
      push_exp(71, 3'b111, 1'b0, 2'd1, "btn_assert");
      push_release(78, 2'd1, "btn");
      apply_stimulus(60, 1'b0, 1'b0);
      apply_stimulus(68, 1'b1, 1'b0);

      $display("[TB] simultaneous press and request, then request mid-release");
      c3 = 110;
      push_exp(c3 + 11, 3'b111, 1'b0, 2'd1, "simul_assert");
      push_exp(c3 + 34, 3'b110, 1'b0, 2'd1, "simul_stage0");
      push_exp(c3 + 35, 3'b111, 1'b0, 2'd2, "midrel_assert");
      push_release(c3 + 35, 2'd2, "midrel");
      apply_stimulus(c3, 1'b0, 1'b0);
      apply_stimulus(c3 + 8, 1'b1, 1'b0);
      apply_stimulus(c3 + 10, 1'b1, 1'b1);
      apply_stimulus(c3 + 11, 1'b1, 1'b0);
      apply_stimulus(c3 + 34, 1'b1, 1'b1);
      apply_stimulus(c3 + 35, 1'b1, 1'b0);

      $display("[TB] held request");
      push_exp(181, 3'b111, 1'b0, 2'd2, "held_assert");
      push_release(231, 2'd2, "held");
      apply_stimulus(180, 1'b1, 1'b1);
      wait_to(220);
      check_output("held_stage", 8'(stage_rst), 8'b111);
      apply_stimulus(231, 1'b1, 1'b0);

      $display("[TB] asynchronous reset mid-run");
      wait_to(279);
      @(posedge clk);
      #2;
      push_exp(cyc, 3'b111, 1'b0, 2'd0, "async_rst");
      rst = 1'b1;
      #1;
      check_output("async_stage", 8'(stage_rst), 8'b111);
      check_output("async_all_released", 8'(all_released), 8'd0);
      check_output("async_cause", 8'(cause), 8'd0);
      wait_to(283);
      rst = 1'b0;
      push_release(283, 2'd0, "por2");
      wait_to(283 + 32);

      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         errors++;
         $display("[TB] FAIL %s: no transition seen, required cycle %0d value %b",
                  e.name, e.cyc, {e.stage, e.rel, e.cause});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
